// File: rtl/branch_predictor.sv
// Direct-mapped branch predictor with 2-bit counters, EX-stage misprediction check and perf counters.
// Lookup and resolution are combinational; the table trains one branch per cycle with no backpressure.
module branch_predictor #(
  parameter int IDX_BITS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] if_pc,
  output logic        pred_taken,
  output logic [31:0] pred_target,
  input  logic        ex_valid,
  input  logic [31:0] ex_pc,
  input  logic [31:0] ex_target,
  input  logic        ex_taken,
  input  logic        ex_pred_taken,
  input  logic [31:0] ex_pred_target,
  output logic        mispredict,
  output logic [31:0] redirect_pc,
  output logic [31:0] branch_cnt,
  output logic [31:0] mispred_cnt
);
  localparam int ENTRIES = 1 << IDX_BITS;
  localparam int TAG_W   = 30 - IDX_BITS;

  logic             valid_q  [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [31:0]      target_q [ENTRIES];
  logic [1:0]       ctr_q    [ENTRIES];

  logic [IDX_BITS-1:0] if_idx, ex_idx;
  logic [TAG_W-1:0]    if_tag, ex_tag;
  logic                if_hit, ex_hit;

  assign if_idx = if_pc[IDX_BITS+1:2];
  assign if_tag = if_pc[31:IDX_BITS+2];
  assign ex_idx = ex_pc[IDX_BITS+1:2];
  assign ex_tag = ex_pc[31:IDX_BITS+2];

  assign if_hit = valid_q[if_idx] && (tag_q[if_idx] == if_tag);
  assign ex_hit = valid_q[ex_idx] && (tag_q[ex_idx] == ex_tag);

  // Lookup reads the registered table only, so a same-cycle update is not bypassed.
  assign pred_taken  = if_hit && ctr_q[if_idx][1];
  assign pred_target = pred_taken ? target_q[if_idx] : if_pc + 32'd4;

  assign mispredict  = ex_valid &&
                       ((ex_taken != ex_pred_taken) ||
                        (ex_taken && (ex_pred_target != ex_target)));
  assign redirect_pc = ex_taken ? ex_target : ex_pc + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= 2'b01;
      end
      branch_cnt  <= '0;
      mispred_cnt <= '0;
    end else begin
      if (ex_valid) begin
        branch_cnt <= branch_cnt + 32'd1;
        if (ex_hit) begin
          if (ex_taken) begin
            if (ctr_q[ex_idx] != 2'b11) ctr_q[ex_idx] <= ctr_q[ex_idx] + 2'd1;
            target_q[ex_idx] <= ex_target;
          end else if (ctr_q[ex_idx] != 2'b00) begin
            ctr_q[ex_idx] <= ctr_q[ex_idx] - 2'd1;
          end
        end else if (ex_taken) begin
          // Allocation evicts whatever aliasing branch held this index.
          valid_q[ex_idx]  <= 1'b1;
          tag_q[ex_idx]    <= ex_tag;
          target_q[ex_idx] <= ex_target;
          ctr_q[ex_idx]    <= 2'b10;
        end
      end
      if (mispredict) mispred_cnt <= mispred_cnt + 32'd1;
    end
  end
endmodule

// File: tb/tb_branch_predictor.sv
// Directed vector table plus randomized run against a behavioural model of the predictor.
module tb_branch_predictor;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] if_pc;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        ex_valid;
  logic [31:0] ex_pc, ex_target;
  logic        ex_taken, ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic        mispredict;
  logic [31:0] redirect_pc, branch_cnt, mispred_cnt;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  branch_predictor #(.IDX_BITS(4)) dut (
    .clk(clk), .rst(rst), .if_pc(if_pc), .pred_taken(pred_taken), .pred_target(pred_target),
    .ex_valid(ex_valid), .ex_pc(ex_pc), .ex_target(ex_target), .ex_taken(ex_taken),
    .ex_pred_taken(ex_pred_taken), .ex_pred_target(ex_pred_target),
    .mispredict(mispredict), .redirect_pc(redirect_pc),
    .branch_cnt(branch_cnt), .mispred_cnt(mispred_cnt)
  );

  typedef struct {
    logic        ev;
    logic [31:0] epc, etgt;
    logic        etk, eptk;
    logic [31:0] eptgt, ipc;
    logic        xpt;
    logic [31:0] xptgt;
    logic        xmis;
    logic [31:0] xred;
  } vec_t;

  vec_t vecs[21];

  function automatic vec_t mk(logic ev, logic [31:0] epc, logic [31:0] etgt, logic etk, logic eptk,
                              logic [31:0] eptgt, logic [31:0] ipc, logic xpt, logic [31:0] xptgt,
                              logic xmis, logic [31:0] xred);
    vec_t v;
    v.ev = ev; v.epc = epc; v.etgt = etgt; v.etk = etk; v.eptk = eptk; v.eptgt = eptgt;
    v.ipc = ipc; v.xpt = xpt; v.xptgt = xptgt; v.xmis = xmis; v.xred = xred;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: 16 entries indexed by word address mod 16, counter as integer 0..3.
  bit          m_valid[16];
  int unsigned m_tag[16];
  logic [31:0] m_tgt[16];
  int          m_ctr[16];
  int unsigned m_bc, m_mc;

  function automatic int m_idx(logic [31:0] pc);
    return int'((pc >> 2) % 16);
  endfunction

  task automatic m_reset();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 0; m_tag[i] = 0; m_tgt[i] = 0; m_ctr[i] = 1;
    end
    m_bc = 0; m_mc = 0;
  endtask

  task automatic m_lookup(input logic [31:0] pc, output logic t, output logic [31:0] tg);
    int i = m_idx(pc);
    t  = m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_ctr[i] >= 2);
    tg = t ? m_tgt[i] : pc + 32'd4;
  endtask

  function automatic logic m_mis();
    if (!ex_valid) return 1'b0;
    if (ex_taken != ex_pred_taken) return 1'b1;
    return ex_taken && (ex_pred_target != ex_target);
  endfunction

  task automatic m_clock(input logic r);
    int i = m_idx(ex_pc);
    bit hit = m_valid[i] && (m_tag[i] == (ex_pc >> 6));
    if (r) begin
      m_reset();
      return;
    end
    if (m_mis()) m_mc++;
    if (!ex_valid) return;
    m_bc++;
    if (hit && ex_taken) begin
      m_ctr[i] = (m_ctr[i] == 3) ? 3 : m_ctr[i] + 1;
      m_tgt[i] = ex_target;
    end else if (hit) begin
      m_ctr[i] = (m_ctr[i] == 0) ? 0 : m_ctr[i] - 1;
    end else if (ex_taken) begin
      m_valid[i] = 1; m_tag[i] = ex_pc >> 6; m_tgt[i] = ex_target; m_ctr[i] = 2;
    end
  endtask

  task automatic drive_idle();
    ex_valid = 0; ex_pc = 0; ex_target = 0; ex_taken = 0; ex_pred_taken = 0; ex_pred_target = 0;
  endtask

  task automatic do_reset();
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
  endtask

  task automatic br(logic [31:0] pc, logic [31:0] tgt, logic tk, logic ptk, logic [31:0] ptgt);
    ex_valid = 1; ex_pc = pc; ex_target = tgt; ex_taken = tk; ex_pred_taken = ptk; ex_pred_target = ptgt;
    @(posedge clk); #1;
    drive_idle();
  endtask

  initial begin
    logic        et;
    logic [31:0] etg;

    vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0);
    vecs[1]  = mk(1, 32'h100, 32'h80, 1, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80);
    vecs[2]  = mk(1, 32'h100, 32'h80, 1, 1, 32'h80, 32'h100, 1, 32'h80, 0, 32'h80);
    vecs[3]  = mk(1, 32'h100, 32'h80, 1, 1, 32'h80, 32'h100, 1, 32'h80, 0, 32'h80);
    vecs[4]  = mk(1, 32'h100, 32'h80, 0, 1, 32'h80, 32'h100, 1, 32'h80, 1, 32'h104);
    vecs[5]  = mk(1, 32'h100, 32'h80, 0, 1, 32'h80, 32'h100, 1, 32'h80, 1, 32'h104);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0);
    vecs[7]  = mk(1, 32'h100, 32'h80, 0, 0, 32'h104, 32'h100, 0, 32'h104, 0, 32'h104);
    vecs[8]  = mk(1, 32'h100, 32'h80, 0, 0, 32'h104, 32'h100, 0, 32'h104, 0, 32'h104);
    vecs[9]  = mk(1, 32'h100, 32'h80, 1, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80);
    vecs[10] = mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0);
    vecs[11] = mk(1, 32'h100, 32'h80, 1, 0, 32'h104, 32'h100, 0, 32'h104, 1, 32'h80);
    vecs[12] = mk(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h80, 0, 0);
    vecs[13] = mk(1, 32'h100, 32'h200, 1, 1, 32'h80, 32'h100, 1, 32'h80, 1, 32'h200);
    vecs[14] = mk(0, 0, 0, 0, 0, 0, 32'h100, 1, 32'h200, 0, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 32'h140, 0, 32'h144, 0, 0);
    vecs[16] = mk(1, 32'h140, 32'h300, 1, 0, 32'h144, 32'h140, 0, 32'h144, 1, 32'h300);
    vecs[17] = mk(0, 0, 0, 0, 0, 0, 32'h100, 0, 32'h104, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 0, 0, 32'h140, 1, 32'h300, 0, 0);
    vecs[19] = mk(1, 32'hFFFFFFFC, 32'h40, 0, 0, 32'h0, 32'hFFFFFFFC, 0, 32'h0, 0, 32'h0);
    vecs[20] = mk(0, 0, 0, 0, 0, 0, 32'h142, 1, 32'h300, 0, 0);

    drive_idle();
    if_pc = 32'h100;
    do_reset();
    #1;
    chk("reset_pred_taken", pred_taken, 0);
    chk("reset_pred_target", pred_target, 32'h104);
    chk("reset_branch_cnt", branch_cnt, 0);
    chk("reset_mispred_cnt", mispred_cnt, 0);
    chk("reset_mispredict", mispredict, 0);

    for (int v = 0; v < 21; v++) begin
      ex_valid = vecs[v].ev; ex_pc = vecs[v].epc; ex_target = vecs[v].etgt;
      ex_taken = vecs[v].etk; ex_pred_taken = vecs[v].eptk; ex_pred_target = vecs[v].eptgt;
      if_pc = vecs[v].ipc;
      #1;
      chk($sformatf("vec%0d_pred_taken", v), pred_taken, vecs[v].xpt);
      chk($sformatf("vec%0d_pred_target", v), pred_target, vecs[v].xptgt);
      chk($sformatf("vec%0d_mispredict", v), mispredict, vecs[v].xmis);
      if (vecs[v].ev) chk($sformatf("vec%0d_redirect", v), redirect_pc, vecs[v].xred);
      @(posedge clk); #1;
    end
    drive_idle();
    chk("table_branch_cnt", branch_cnt, 12);
    chk("table_mispred_cnt", mispred_cnt, 7);

    // Reset together with a taken branch: update and counting are both dropped.
    rst = 1;
    ex_valid = 1; ex_pc = 32'h100; ex_target = 32'h80; ex_taken = 1; ex_pred_taken = 0; ex_pred_target = 32'h104;
    @(posedge clk); #1;
    rst = 0;
    drive_idle();
    if_pc = 32'h100;
    #1;
    chk("rstmid_branch_cnt", branch_cnt, 0);
    chk("rstmid_mispred_cnt", mispred_cnt, 0);
    chk("rstmid_pred_taken", pred_taken, 0);
    if_pc = 32'h140;
    #1;
    chk("rstmid_alias_pred_taken", pred_taken, 0);

    br(32'h200, 32'h280, 0, 0, 32'h204);
    br(32'h208, 32'h300, 1, 0, 32'h20C);
    br(32'h210, 32'h290, 0, 0, 32'h214);
    br(32'h218, 32'h400, 1, 0, 32'h21C);
    br(32'h220, 32'h2A0, 0, 0, 32'h224);
    chk("five_branch_cnt", branch_cnt, 5);
    chk("five_mispred_cnt", mispred_cnt, 2);

    m_reset();
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      logic [31:0] pool_pc;
      rst = ($urandom_range(0, 149) == 0);
      pool_pc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'b00};
      if_pc = ($urandom_range(0, 3) == 0) ? $urandom : pool_pc | 32'($urandom_range(0, 3));
      ex_valid = $urandom_range(0, 2) != 0;
      ex_pc = {24'h0, 2'($urandom_range(0, 3)), 4'($urandom), 2'($urandom)};
      if ($urandom_range(0, 19) == 0) ex_pc = 32'hFFFFFFFC;
      ex_target = ($urandom_range(0, 1) != 0) ? 32'h80 : {$urandom} & 32'hFFFFFFFC;
      ex_taken = $urandom_range(0, 1);
      m_lookup(ex_pc, et, etg);
      if ($urandom_range(0, 3) != 0) begin
        ex_pred_taken = et; ex_pred_target = etg;
      end else begin
        ex_pred_taken = $urandom_range(0, 1);
        ex_pred_target = ($urandom_range(0, 1) != 0) ? ex_target : $urandom;
      end
      #1;
      m_lookup(if_pc, et, etg);
      if (!rst) begin
        chk("rnd_pred_taken", pred_taken, et);
        chk("rnd_pred_target", pred_target, etg);
      end
      chk("rnd_mispredict", mispredict, m_mis());
      if (ex_valid) chk("rnd_redirect", redirect_pc, ex_taken ? ex_target : ex_pc + 32'd4);
      m_clock(rst);
      @(posedge clk); #1;
      chk("rnd_branch_cnt", branch_cnt, m_bc);
      chk("rnd_mispred_cnt", mispred_cnt, m_mc);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
